// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: adds two 4*NIBBLES-bit operands one nibble per cycle through a shared external 4-bit adder.
// Optional macro ADDSEQ_SUB_EN adds a sub port for A-B mode.
module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin,
`ifdef ADDSEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_s,
  input  logic                 add_cout
);
  localparam int W = 4*NIBBLES;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_q, sum_d, b_in;
  logic [2:0] idx_q, idx_d;
  logic carry_q, carry_d, cout_q, cout_d, c_in, accept, run, last;
`ifdef ADDSEQ_SUB_EN
  // two's-complement subtract: invert B and force the initial carry
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub | cin;
`else
  assign b_in = op_b;
  assign c_in = cin;
`endif
  assign accept = (state_q == IDLE) && start;
  assign run    = state_q == RUN;
  assign last   = idx_q == 3'(NIBBLES-1);
  assign sum    = sum_q;
  assign cout   = cout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    a_sr_d  = accept ? op_a : run ? a_sr_q >> 4 : a_sr_q;
    b_sr_d  = accept ? b_in : run ? b_sr_q >> 4 : b_sr_q;
    sum_d   = accept ? '0 : run ? {add_s, sum_q[W-1:4]} : sum_q;
    idx_d   = accept ? 3'd0 : run ? idx_q + 3'd1 : idx_q;
    carry_d = accept ? c_in : run ? add_cout : carry_q;
    cout_d  = accept ? 1'b0 : (run && last) ? add_cout : cout_q;
  end
  always_comb begin
    busy    = state_q != IDLE;
    done    = state_q == DONE;
    add_a   = run ? a_sr_q[3:0] : 4'd0;
    add_b   = run ? b_sr_q[3:0] : 4'd0;
    add_cin = run & carry_q;
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: randomized and directed checks of adder_seq_ctrl against a plain-arithmetic reference.
module tb_adder_seq_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, sum;
  logic busy, done, cout, add_cin, add_cout;
  logic [3:0] add_a, add_b, add_s;
  int checks = 0, errors = 0;

  adder_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADDSEQ_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
  );

  always #5 clk = ~clk;
  // the shared 4-bit adder the sequencer drives
  assign {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    logic [W-1:0] d;
    d = a - b;
    return s ? {a >= b, d} : (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s,
                       output int lat, output int bcnt, output logic [W-1:0] r, output logic co,
                       output logic [W-1:0] oa, output logic [W-1:0] ob, output logic oc,
                       output logic d_after, output logic b_after);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op_a = ~a; op_b = ~b; cin = ~c; sub = 1'b0;
    lat = 0; bcnt = 0; oa = '0; ob = '0; oc = add_cin;
    while (!done && lat < 3*N) begin
      bcnt += int'(busy);
      oa = {add_a, oa[W-1:4]};
      ob = {add_b, ob[W-1:4]};
      @(negedge clk);
      lat++;
    end
    lat++;
    bcnt += int'(busy);
    r = sum; co = cout;
    @(negedge clk);
    d_after = done; b_after = busy;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL reset_sum got %h/%b want 0/0", sum, cout); end
    checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin errors++; $display("FAIL reset_adder got %h %h %b want 0", add_a, add_b, add_cin); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5], tb_ [5], r, oa, ob;
    logic tc [5];
    logic co, oc, da, ba;
    logic [W:0] e;
    int lat, bc;
    ta  = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF};
    tb_ = '{16'h0FFF, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      e = ref_op(ta[i], tb_[i], tc[i], 1'b0);
      do_op(ta[i], tb_[i], tc[i], 1'b0, lat, bc, r, co, oa, ob, oc, da, ba);
      checks++; if (r !== e[W-1:0]) begin errors++; $display("FAIL dir%0d_sum got %h want %h", i, r, e[W-1:0]); end
      checks++; if (co !== e[W]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, co, e[W]); end
      checks++; if (lat != N+1) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, N+1); end
      checks++; if (bc != N+1) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, N+1); end
      checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL dir%0d_after_done got done=%b busy=%b want 0 0", i, da, ba); end
      checks++; if (oa !== ta[i] || ob !== tb_[i]) begin errors++; $display("FAIL dir%0d_nibbles got %h %h want %h %h", i, oa, ob, ta[i], tb_[i]); end
      checks++; if (oc !== tc[i]) begin errors++; $display("FAIL dir%0d_first_cin got %b want %b", i, oc, tc[i]); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, oa, ob;
    logic c, co, oc, da, ba;
    logic [W:0] e;
    int lat, bc;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      e = ref_op(a, b, c, 1'b0);
      do_op(a, b, c, 1'b0, lat, bc, r, co, oa, ob, oc, da, ba);
      checks++; if ({co, r} !== e) begin errors++; $display("FAIL rand%0d got %b_%h want %b_%h", i, co, r, e[W], e[W-1:0]); end
      checks++; if (lat != N+1) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, N+1); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] a, b, r;
    logic co;
    logic [W:0] e;
    int dcount;
    a = W'($urandom); b = W'($urandom);
    e = ref_op(a, b, 1'b1, 1'b0);
    r = '0; co = 1'b0; dcount = 0;
    @(negedge clk);
    op_a = a; op_b = b; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin dcount++; r = sum; co = cout; end
      start = (k == 1 || k == 3 || k == 4);
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (dcount != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dcount); end
    checks++; if ({co, r} !== e) begin errors++; $display("FAIL ignore_result got %b_%h want %b_%h", co, r, e[W], e[W-1:0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] a, b, r, oa, ob;
    logic co, oc, da, ba;
    logic [W:0] e;
    int lat, bc, dcount;
    @(negedge clk);
    op_a = 16'h5A5F; op_b = 16'h3C3C; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_ctrl got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL areset_sum got %h/%b want 0/0", sum, cout); end
    checks++; if ({add_a, add_b, add_cin} !== 9'd0) begin errors++; $display("FAIL areset_adder got %h %h %b want 0", add_a, add_b, add_cin); end
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 8; k++) begin
      dcount += int'(done);
      @(negedge clk);
    end
    checks++; if (dcount != 0) begin errors++; $display("FAIL areset_discard got %0d done pulses want 0", dcount); end
    a = W'($urandom); b = W'($urandom);
    e = ref_op(a, b, 1'b0, 1'b0);
    do_op(a, b, 1'b0, 1'b0, lat, bc, r, co, oa, ob, oc, da, ba);
    checks++; if ({co, r} !== e) begin errors++; $display("FAIL areset_after got %b_%h want %b_%h", co, r, e[W], e[W-1:0]); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W:0] e;
    logic want;
    a = W'($urandom); b = W'($urandom);
    e = ref_op(a, b, 1'b1, 1'b0);
    @(negedge clk);
    op_a = a; op_b = b; cin = 1'b1; start = 1'b1;
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      if (k == 19) start = 1'b0;
      want = (k % 6 == 4);
      checks++; if (done !== want) begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, want); end
      if (want) begin
        checks++; if ({cout, sum} !== e) begin errors++; $display("FAIL b2b_result k=%0d got %b_%h want %b_%h", k, cout, sum, e[W], e[W-1:0]); end
      end
    end
  endtask

`ifdef ADDSEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] ta [3], tb_ [3], r, oa, ob;
    logic co, oc, da, ba;
    logic [W:0] e;
    int lat, bc;
    ta  = '{16'h0005, 16'h0007, W'($urandom)};
    tb_ = '{16'h0007, 16'h0005, W'($urandom)};
    for (int i = 0; i < 3; i++) begin
      e = ref_op(ta[i], tb_[i], 1'b0, 1'b1);
      do_op(ta[i], tb_[i], 1'($urandom), 1'b1, lat, bc, r, co, oa, ob, oc, da, ba);
      checks++; if ({co, r} !== e) begin errors++; $display("FAIL sub%0d got %b_%h want %b_%h", i, co, r, e[W], e[W-1:0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
`ifdef ADDSEQ_SUB_EN
    test_sub();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
